dense_backprop_calculator: RTL

Consumes the per-neuron z-to-z error vector produced by the z-to-z stage and back-propagates it through the current layer's weight matrix. It produces the diff_dense vector that the previous layer's z-to-z stage consumes: diff_dense[j] = sum over i of W[i][j] * delta[i]. Weight rows are streamed in one per handshake. The result is presented on a valid/ready output.

---
 rtl/fixed_point_pkg.sv | 35 +++
 rtl/fixed_mac_lane.sv | 51 +++++
 rtl/dense_backprop_calculator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fixed_point_pkg.sv
// ---------------------------------------------------------------------------
// fixed_point_pkg
// Shared definitions for the dense back-propagation datapath.
//   DATA_SIZE : width of one signed Q8.8 element
//   FRAC_BITS : number of fractional bits (DATA_SIZE/2)
//   state_t   : control states of the back-prop calculator
//   sat_data  : clamps a wide signed value into the DATA_SIZE range
// ---------------------------------------------------------------------------
package fixed_point_pkg;

    localparam int DATA_SIZE = 16;
    localparam int FRAC_BITS = DATA_SIZE / 2;

    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_SIZE - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -SAT_MAX - 64'sd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Callers sign-extend their value to 64 bits first, so one function
    // serves any accumulator width up to 64.
    function automatic logic signed [DATA_SIZE-1:0] sat_data(input logic signed [63:0] i_x);
        if (i_x > SAT_MAX) begin
            return {1'b0, {(DATA_SIZE-1){1'b1}}};
        end else if (i_x < SAT_MIN) begin
            return {1'b1, {(DATA_SIZE-1){1'b0}}};
        end else begin
            return i_x[DATA_SIZE-1:0];
        end
    endfunction

endpackage

// File: rtl/fixed_mac_lane.sv
// ---------------------------------------------------------------------------
// fixed_mac_lane
// One signed multiply-accumulate lane. Each enabled cycle adds the full-width
// product i_weight * i_delta into a wide accumulator; o_sat is the accumulator
// rescaled back to Q8.8 (arithmetic shift) and saturated.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : zero the accumulator (wins over i_en)
//   i_en       : accumulate this cycle
//   i_weight   : signed weight element
//   i_delta    : signed delta element
//   o_sat      : saturated Q8.8 view of the current accumulator
// ---------------------------------------------------------------------------
module fixed_mac_lane
    import fixed_point_pkg::*;
#(
    parameter int DATA_W = DATA_SIZE,
    parameter int ACC_W  = 2 * DATA_SIZE + 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_weight,
    input  logic signed [DATA_W-1:0] i_delta,
    output logic signed [DATA_W-1:0] o_sat
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_shift;
    logic signed [63:0]         w_shift_ext;
    logic signed [ACC_W-1:0]    r_acc_p0;

    assign w_prod     = i_weight * i_delta;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

    // stage 0: accumulate
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_acc_p0 <= '0;
        end else if (i_en) begin
            r_acc_p0 <= r_acc_p0 + w_prod_ext;
        end
    end

    // rescale: product carried 2*FRAC_BITS fraction bits, drop FRAC_BITS of them
    assign w_shift     = r_acc_p0 >>> FRAC_BITS;
    assign w_shift_ext = {{(64-ACC_W){w_shift[ACC_W-1]}}, w_shift};
    assign o_sat       = sat_data(w_shift_ext);

endmodule

// File: rtl/dense_backprop_calculator.sv
// ---------------------------------------------------------------------------
// dense_backprop_calculator
// Back-propagates the z-to-z error vector through the current layer's weight
// matrix: diff_dense[j] = sum_i W[i][j] * delta[i]. Weight rows stream in one
// per handshake; the result is held in an output register presented with a
// valid/ready pair.
//   clk, reset      : clock, synchronous active-high reset
//   start_new_layer : latch delta, clear accumulators, begin a pass
//   diff_z_to_z     : delta vector, element k at [data_size*(size-k)-1 -: data_size]
//   weight_row      : one row of W, element j at [data_size*(prev_size-j)-1 -: data_size]
//   weight_valid    : weight_row valid
//   weight_ready    : row accepted when valid && ready
//   diff_dense      : result vector, same packing as weight_row
//   dense_valid     : result valid (DONE)
//   dense_ready     : consumer accepts result
//   busy            : pass in progress or result pending
// ---------------------------------------------------------------------------
module dense_backprop_calculator
    import fixed_point_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int size      = 3,
    parameter int prev_size = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_new_layer,
    input  logic [data_size*size-1:0]      diff_z_to_z,
    input  logic [data_size*prev_size-1:0] weight_row,
    input  logic                           weight_valid,
    output logic                           weight_ready,
    output logic [data_size*prev_size-1:0] diff_dense,
    output logic                           dense_valid,
    input  logic                           dense_ready,
    output logic                           busy
);

    localparam int RW    = (size > 1) ? $clog2(size) : 1;
    localparam int ACC_W = 2 * data_size + $clog2(size) + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(size - 1);

    state_t                       r_state;
    logic                         r_weight_ready;
    logic                         r_dense_valid;
    logic                         r_busy;
    logic [RW-1:0]                r_row;
    // Set once the final row is in; the accumulators then need one more
    // edge to settle before the output register samples them.
    logic                         r_rows_done;
    logic signed [data_size-1:0]  r_delta [size];
    logic signed [data_size-1:0]  r_out   [prev_size];
    logic signed [data_size-1:0]  w_sat   [prev_size];
    logic signed [data_size-1:0]  w_delta_sel;
    logic                         w_accept;

    // A start in the same cycle cancels any row handshake; rows arriving
    // after the last one (before DONE) are not accumulated.
    assign w_accept    = weight_valid && (r_state == ACCUM) && !r_rows_done && !start_new_layer;
    assign w_delta_sel = r_delta[r_row];

    genvar j;
    generate
        for (j = 0; j < prev_size; j++) begin : g_lane
            fixed_mac_lane #(
                .DATA_W (data_size),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk      (clk),
                .reset    (reset),
                .i_clr    (start_new_layer),
                .i_en     (w_accept),
                .i_weight (weight_row[data_size*(prev_size-j)-1 -: data_size]),
                .i_delta  (w_delta_sel),
                .o_sat    (w_sat[j])
            );
            assign diff_dense[data_size*(prev_size-j)-1 -: data_size] = r_out[j];
        end
    endgenerate

    // control FSM, row counter, delta latch and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_weight_ready <= 1'b0;
            r_dense_valid  <= 1'b0;
            r_busy         <= 1'b0;
            r_row          <= '0;
            r_rows_done    <= 1'b0;
            for (int k = 0; k < prev_size; k++) begin
                r_out[k] <= '0;
            end
        end else if (start_new_layer) begin
            for (int k = 0; k < size; k++) begin
                r_delta[k] <= diff_z_to_z[data_size*(size-k)-1 -: data_size];
            end
            r_state        <= ACCUM;
            r_weight_ready <= 1'b1;
            r_dense_valid  <= 1'b0;
            r_busy         <= 1'b1;
            r_row          <= '0;
            r_rows_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_weight_ready <= 1'b0;
                    r_dense_valid  <= 1'b0;
                    r_busy         <= 1'b0;
                end
                ACCUM: begin
                    if (r_rows_done) begin
                        for (int k = 0; k < prev_size; k++) begin
                            r_out[k] <= w_sat[k];
                        end
                        r_state        <= DONE;
                        r_weight_ready <= 1'b0;
                        r_dense_valid  <= 1'b1;
                        r_rows_done    <= 1'b0;
                    end else if (w_accept) begin
                        if (r_row == LAST_ROW) begin
                            r_row       <= '0;
                            r_rows_done <= 1'b1;
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end
                end
                DONE: begin
                    if (dense_ready) begin
                        r_state       <= IDLE;
                        r_dense_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_weight_ready <= 1'b0;
                    r_dense_valid  <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign weight_ready = r_weight_ready;
    assign dense_valid  = r_dense_valid;
    assign busy         = r_busy;

endmodule
